// File: rtl/counter_sequencer.sv
// Run controller for the up-counter: latches limit/prescale/mode on start, clears, paces enables, flags done.
// done_o lands 2 + limit*(prescale+1) cycles after start is accepted; stop_i aborts at the next edge.
module counter_sequencer #(
    parameter int WIDTH      = 4,
    parameter int PRESCALE_W = 4,
    parameter int PCOUNT_W   = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_i,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  mode_i,
    input  logic [WIDTH-1:0]      limit_i,
    input  logic [PRESCALE_W-1:0] prescale_i,
    input  logic [WIDTH-1:0]      counter_value_i,
    output logic                  counter_enable_o,
    output logic                  counter_clear_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic [PCOUNT_W-1:0]   period_count_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [PCOUNT_W-1:0] PCOUNT_MAX = '1;

    state_t                state_q, state_d;
    logic                  mode_q, mode_d;
    logic [WIDTH-1:0]      limit_q, limit_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] presc_q, presc_d;
    logic [PCOUNT_W-1:0]   period_count_q, period_count_d;
    logic                  term;
    logic                  enable;
    logic                  done;

    always_comb begin
        state_d        = state_q;
        mode_d         = mode_q;
        limit_d        = limit_q;
        prescale_d     = prescale_q;
        presc_d        = presc_q;
        period_count_d = period_count_q;
        enable         = 1'b0;
        done           = 1'b0;
        term           = (counter_value_i == limit_q);

        case (state_q)
            ST_IDLE: begin
                if (start_i && !stop_i) begin
                    mode_d         = mode_i;
                    limit_d        = limit_i;
                    prescale_d     = prescale_i;
                    period_count_d = '0;
                    state_d        = ST_CLEAR;
                end
            end
            ST_CLEAR: begin
                presc_d = '0;
                state_d = stop_i ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // Stop outranks term; enable is held off at term so the counter never wraps past limit.
                if (stop_i) begin
                    state_d = ST_IDLE;
                end else if (term) begin
                    done    = 1'b1;
                    state_d = mode_q ? ST_CLEAR : ST_IDLE;
                    if (period_count_q != PCOUNT_MAX) begin
                        period_count_d = period_count_q + 1'b1;
                    end
                end else if (presc_q == prescale_q) begin
                    enable  = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q        <= ST_IDLE;
            mode_q         <= 1'b0;
            limit_q        <= '0;
            prescale_q     <= '0;
            presc_q        <= '0;
            period_count_q <= '0;
        end else begin
            state_q        <= state_d;
            mode_q         <= mode_d;
            limit_q        <= limit_d;
            prescale_q     <= prescale_d;
            presc_q        <= presc_d;
            period_count_q <= period_count_d;
        end
    end

    // Outputs are forced low while reset is asserted, before the state register has settled.
    assign counter_enable_o = enable & ~reset_i;
    assign done_o           = done & ~reset_i;
    assign counter_clear_o  = (state_q == ST_CLEAR) & ~reset_i;
    assign busy_o           = (state_q != ST_IDLE) & ~reset_i;
    assign period_count_o   = reset_i ? '0 : period_count_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Scoreboarded random/directed bench for counter_sequencer with a behavioural 4-bit counter beside it.
module tb_counter_sequencer;

    logic       clk = 1'b0;
    logic       reset_i, start_i, stop_i, mode_i;
    logic [3:0] limit_i, prescale_i;
    logic [3:0] cnt = '0;
    logic       en, clr, busy, done;
    logic [7:0] pcount;

    always #5 clk = ~clk;

    counter_sequencer dut (
        .clock_i          (clk),
        .reset_i          (reset_i),
        .start_i          (start_i),
        .stop_i           (stop_i),
        .mode_i           (mode_i),
        .limit_i          (limit_i),
        .prescale_i       (prescale_i),
        .counter_value_i  (cnt),
        .counter_enable_o (en),
        .counter_clear_o  (clr),
        .busy_o           (busy),
        .done_o           (done),
        .period_count_o   (pcount)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Counter datapath: clear has priority, then increment.
    always @(posedge clk) begin
        if (clr)     cnt <= '0;
        else if (en) cnt <= cnt + 4'd1;
    end

    int checks = 0;
    int errors = 0;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
        end
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    typedef struct {
        int cyc;
        int pc;
        int lim;
    } ev_t;

    ev_t sb[$];
    ev_t mon_e;
    int  cur_p    = 0;
    int  last_clr = 0;
    int  en_cnt   = 0;

    always @(negedge clk) begin
        if (clr) begin
            last_clr = cyc;
            en_cnt   = 0;
        end
        if (en) begin
            en_cnt++;
            chk("enable_phase", (cyc - last_clr - 1) % (cur_p + 1), cur_p);
        end
        if (done) begin
            chk("done_expected", int'(sb.size() > 0), 1);
            if (sb.size() > 0) begin
                mon_e = sb.pop_front();
                chk("done_cycle", cyc, mon_e.cyc);
                chk("done_pcount", pcount, mon_e.pc);
                chk("done_counter", cnt, mon_e.lim);
                chk("done_enables", en_cnt, mon_e.lim);
                chk("done_no_enable", en, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_within_budget", busy, 0);
    endtask

    // stop_off is the cycle offset from the start at which stop_i is raised (periodic runs only).
    task automatic start_run(input bit m, input int lim, input int p, input int stop_off);
        int c0, per, nk;
        c0    = cyc;
        cur_p = p;
        per   = lim * (p + 1) + 2;
        nk    = 0;
        start_i    = 1'b1;
        stop_i     = 1'b0;
        mode_i     = m;
        limit_i    = 4'(lim);
        prescale_i = 4'(p);
        if (!m) begin
            sb.push_back(ev_t'{c0 + per, 0, lim});
        end else begin
            for (int k = 0; c0 + per * (k + 1) < c0 + stop_off; k++) begin
                sb.push_back(ev_t'{c0 + per * (k + 1), sat(k), lim});
                nk++;
            end
        end
        step();
        start_i    = 1'b0;
        mode_i     = 1'($urandom_range(0, 1));
        limit_i    = 4'($urandom);
        prescale_i = 4'($urandom);
        if (m) begin
            while (cyc < c0 + stop_off) step();
            stop_i = 1'b1;
            step();
            stop_i = 1'b0;
            @(negedge clk);
            chk("stopped_idle", busy, 0);
            chk("pcount_after_stop", pcount, sat(nk));
        end else begin
            wait_idle(per + 8);
            chk("pcount_oneshot", pcount, 1);
            chk("counter_holds_limit", cnt, lim);
        end
        step();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int r, c0, m, lim, p, per;
        reset_i    = 1'b1;
        start_i    = 1'b1;
        stop_i     = 1'b0;
        mode_i     = 1'b0;
        limit_i    = 4'd1;
        prescale_i = 4'd0;
        repeat (3) step();
        @(negedge clk);
        chk("reset_busy", busy, 0);
        chk("reset_clear", clr, 0);
        chk("reset_enable", en, 0);
        chk("reset_done", done, 0);
        chk("reset_pcount", pcount, 0);

        // Start held through reset is taken on the first edge after release.
        step();
        reset_i = 1'b0;
        r       = cyc;
        cur_p   = 0;
        sb.push_back(ev_t'{r + 3, 0, 1});
        step();
        start_i = 1'b0;
        @(negedge clk);
        chk("clear_after_reset_release", clr, 1);
        wait_idle(10);
        step();

        start_run(0, 5, 0, 0);
        start_run(0, 3, 2, 0);
        start_run(1, 2, 0, 10);
        start_run(0, 0, 0, 0);
        start_run(0, 15, 0, 0);
        start_run(1, 1, 0, 6);

        // start and stop together: stop wins.
        start_i = 1'b1;
        stop_i  = 1'b1;
        limit_i = 4'd3;
        step();
        start_i = 1'b0;
        stop_i  = 1'b0;
        @(negedge clk);
        chk("start_stop_busy", busy, 0);
        chk("start_stop_clear", clr, 0);
        step();

        // start pulsed mid-run with different settings is ignored.
        c0         = cyc;
        cur_p      = 1;
        start_i    = 1'b1;
        mode_i     = 1'b0;
        limit_i    = 4'd6;
        prescale_i = 4'd1;
        sb.push_back(ev_t'{c0 + 14, 0, 6});
        step();
        start_i = 1'b0;
        repeat (4) step();
        start_i    = 1'b1;
        mode_i     = 1'b1;
        limit_i    = 4'd2;
        prescale_i = 4'd0;
        step();
        start_i = 1'b0;
        wait_idle(30);
        chk("ignored_start_counter", cnt, 6);
        repeat (3) step();
        @(negedge clk);
        chk("ignored_start_no_restart", busy, 0);
        step();

        // Reset in the middle of a run.
        c0         = cyc;
        cur_p      = 0;
        start_i    = 1'b1;
        mode_i     = 1'b0;
        limit_i    = 4'd10;
        prescale_i = 4'd0;
        step();
        start_i = 1'b0;
        while (cyc < c0 + 4) step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        @(negedge clk);
        chk("midreset_busy", busy, 0);
        chk("midreset_enable", en, 0);
        chk("midreset_done", done, 0);
        chk("midreset_clear", clr, 0);
        chk("midreset_pcount", pcount, 0);
        repeat (15) step();

        start_run(1, 0, 0, 600);

        for (int i = 0; i < 30; i++) begin
            m   = $urandom_range(0, 1);
            lim = $urandom_range(0, 15);
            p   = $urandom_range(0, 15);
            per = lim * (p + 1) + 2;
            start_run(m[0], lim, p, $urandom_range(1, 3 * per));
            repeat ($urandom_range(0, 3)) step();
        end

        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/counter_sequencer.md
Name: counter_sequencer

Overview:
- Run-controller for the 4-bit up-counter datapath.
- Accepts a start command with a latched limit, prescale and mode, then clears the counter.
- Paces the counter's enable input through a prescaler and detects the terminal value.
- Signals completion, then idles (one-shot) or reloads and repeats (periodic). Sits beside the counter in the board top; the top level inverts counter_clear_o onto the counter's active-low reset.

Parameters:
WIDTH, 4, counter width; width of limit_i and counter_value_i
PRESCALE_W, 4, width of prescale_i and of the internal prescaler
PCOUNT_W, 8, width of period_count_o

Ports:
clock_i  in  1  single clock; all state updates on rising edge
reset_i  in  1  synchronous, active-high reset
start_i  in  1  start request; sampled only in IDLE
stop_i  in  1  abort request; sampled in CLEAR and RUN
mode_i  in  1  0 = one-shot, 1 = periodic; latched on start
limit_i  in  WIDTH  terminal counter value; latched on start
prescale_i  in  PRESCALE_W  enable every prescale+1 RUN cycles; latched on start
counter_value_i  in  WIDTH  current counter output
counter_enable_o  out  1  increment strobe to counter
counter_clear_o  out  1  clear request to counter; counter reads 0 in the following cycle
busy_o  out  1  high in CLEAR and RUN
done_o  out  1  one-cycle pulse when limit reached
period_count_o  out  PCOUNT_W  completed runs since last accepted start; saturating

Behaviour:
- Reset (reset_i=1 at an edge): state IDLE, prescaler 0, period_count 0. All outputs 0 during and after reset. Reset mid-run aborts immediately with no done_o. The block never clears the counter on its own reset.
- States: IDLE, CLEAR, RUN (2-bit encoding).
- IDLE (busy_o=0):
  - start_i=1 and stop_i=0: latch mode/limit/prescale, clear period_count, go to CLEAR.
  - start_i and stop_i both 1: stop wins; stay in IDLE.
- CLEAR (counter_clear_o=1, busy_o=1, exactly one cycle):
  - prescaler cleared; next state RUN.
  - stop_i=1: go to IDLE instead.
- RUN (busy_o=1):
  - term = (counter_value_i == limit_q). counter_enable_o and done_o are combinational from state, prescaler and term; all else registered.
  - stop_i=1: go to IDLE, counter_enable_o=0, done_o=0. Stop has priority over term.
  - else if term: done_o=1, counter_enable_o=0, period_count += 1 (saturating at 2^PCOUNT_W-1). Next state IDLE if mode_q=0, CLEAR if mode_q=1.
  - else: counter_enable_o=1 when prescaler == prescale_q, and prescaler wraps to 0. Otherwise prescaler increments.
- Latency, with start accepted at cycle 0:
  - CLEAR at cycle 1; first RUN cycle at cycle 2.
  - done_o at cycle 2 + limit*(prescale+1).
  - Periodic period is limit*(prescale+1) + 2 cycles.
- Boundaries:
  - limit=0 gives done_o in the first RUN cycle with no enable.
  - limit=2^WIDTH-1 completes without the counter wrapping, since enable is suppressed at term.
  - prescale=0 gives an enable on every non-terminal RUN cycle.
  - start_i while busy is ignored. Inputs other than stop_i are ignored while busy.
  - After a one-shot run the counter holds limit; it is not cleared until the next start.

Test Plan:
- Reset with start_i=1 held -> all outputs 0, state IDLE; after reset release the start is accepted on the next edge.
- One-shot, limit=5, prescale=0, start at cycle 0 -> clear_o at cycle 1; enables at cycles 2-6; done_o only at cycle 7; counter ends at 5; busy_o low from cycle 8; period_count=1.
- One-shot, limit=3, prescale=2 -> enables at cycles 4, 7, 10; done_o at cycle 11; no enable at cycle 11.
- Periodic, limit=2, prescale=0 -> done_o at cycles 4, 8, 12; clear_o at cycles 1, 5, 9; period_count 1, 2, 3; stop_i at cycle 10 -> IDLE at cycle 11, no done_o at cycle 12.
- limit=0 -> done_o at cycle 2, zero enables. limit=15, prescale=0 -> done_o at cycle 17, counter=15, no wrap.
- Corners:
  - start_i and stop_i together in IDLE -> no start.
  - start_i pulsed during RUN -> ignored.
  - reset_i at cycle 4 of a run -> outputs 0 next cycle, no done_o.
  - periodic limit=0 run for 600 cycles -> period_count saturates at 255.
